// File: rtl/soc_mem_pkg.sv
// Shared definitions for the cpu memory subsystem.
//   - AW_DEF / DW_DEF : default address/data widths shared with the cpu core
//   - ST_BOOT / ST_START / ST_RUN : bring-up state encodings (visible on state_o)
//   - reset_state() : state entered when leaving reset
package soc_mem_pkg;

  localparam int unsigned AW_DEF = 12;
  localparam int unsigned DW_DEF = 16;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  function automatic logic [1:0] reset_state(input int unsigned boot_on_reset);
    return (boot_on_reset != 0) ? ST_BOOT : ST_START;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   i_clk  : clock, state on posedge
//   i_rst  : synchronous reset, active-high (count -> 0)
//   i_inc  : increment request (ignored once count reaches LIMIT)
//   i_clr  : synchronous clear, wins over i_inc
//   o_sat  : count == LIMIT
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LimitVal)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == LimitVal);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port program/data RAM between the cpu core and a boot/debug
// loader, and sequences cpu bring-up (BOOT -> START -> RUN).
//   clkin, rst                 : clock and synchronous active-high reset
//   cpu_en/rdwr/addr/wdata     : cpu bus request; cpu_rdata returns RAM read data
//   cpu_rst                    : registered reset to the cpu core
//   ldr_req/we/addr/wdata      : loader request; ldr_gnt = access performed this cycle
//   ldr_rvalid, ldr_rdata      : loader read return, one cycle after a read grant
//   boot_done, halt_req        : start the cpu / send it back to BOOT
//   mem_en/we/addr/wdata/rdata : RAM macro port (1-cycle read latency)
//   state_o                    : current state (BOOT=0, START=1, RUN=2)
//   ldr_starved                : loader refused STARVE_LIMIT consecutive cycles in RUN
module mem_bus_arbiter
  import soc_mem_pkg::*;
#(
  parameter int unsigned AW            = AW_DEF,
  parameter int unsigned DW            = DW_DEF,
  parameter int unsigned BOOT_ON_RESET = 1,
  parameter int unsigned RST_HOLD      = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          cpu_en,
  input  logic          cpu_rdwr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rst,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  input  logic          boot_done,
  input  logic          halt_req,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state_o,
  output logic          ldr_starved
);

  localparam logic [3:0] HoldLast = 4'(RST_HOLD - 1);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_hold_cnt;
  logic       r_cpu_rst;
  logic       r_ldr_rvalid;
  logic       w_run;
  logic       w_cpu_sel;
  logic       w_ldr_gnt;
  logic       w_starve_inc;
  logic       w_starve_clr;
  logic       w_starve_sat;

  assign w_run = (r_state == ST_RUN);

  // The cpu only drives the bus in RUN and only on cycles it actually requests;
  // every other cycle is available to the loader.
  assign w_cpu_sel = w_run & cpu_en;
  assign w_ldr_gnt = ldr_req & ~w_cpu_sel;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT:  if (boot_done) w_state_nxt = ST_START;
      ST_START: if (r_hold_cnt == HoldLast) w_state_nxt = ST_RUN;
      ST_RUN:   if (halt_req) w_state_nxt = ST_BOOT;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state      <= reset_state(BOOT_ON_RESET);
      r_cpu_rst    <= 1'b1;
      r_hold_cnt   <= '0;
      r_ldr_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_rst    <= (w_state_nxt != ST_RUN);
      r_ldr_rvalid <= w_ldr_gnt & ~ldr_we;
      // Held at zero outside START so it always enters START cleared.
      if (r_state == ST_START) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ldr_addr;
    mem_wdata = ldr_wdata;
    if (w_cpu_sel) begin
      mem_en    = 1'b1;
      mem_we    = cpu_rdwr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ldr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
    end
  end

  // Counter is cleared outside RUN, but the flag is also gated so it drops on the
  // very first non-RUN cycle.
  assign w_starve_inc = w_run & ldr_req & ~w_ldr_gnt;
  assign w_starve_clr = ~w_run | w_ldr_gnt | ~ldr_req;

  sat_counter #(
    .WIDTH (8),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .i_clk (clkin),
    .i_rst (rst),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_sat (w_starve_sat)
  );

  assign ldr_gnt     = w_ldr_gnt;
  assign ldr_rvalid  = r_ldr_rvalid;
  assign ldr_rdata   = mem_rdata;
  assign cpu_rdata   = mem_rdata;
  assign cpu_rst     = r_cpu_rst;
  assign state_o     = r_state;
  assign ldr_starved = w_run & w_starve_sat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_en = 1'b0;
  logic        cpu_rdwr = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_rst;
  logic        ldr_req = 1'b0;
  logic        ldr_we = 1'b0;
  logic [11:0] ldr_addr = '0;
  logic [15:0] ldr_wdata = '0;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [15:0] ldr_rdata;
  logic        boot_done = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  state_o;
  logic        ldr_starved;

  int checks = 0;
  int failures = 0;

  logic [15:0] ram [0:4095];
  logic [15:0] exp_mem [0:4095];
  logic [15:0] sb_q [$];
  logic [15:0] sb_exp;

  always #5 clkin = ~clkin;

  mem_bus_arbiter dut (
    .clkin       (clkin),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_rdwr    (cpu_rdwr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_rst     (cpu_rst),
    .ldr_req     (ldr_req),
    .ldr_we      (ldr_we),
    .ldr_addr    (ldr_addr),
    .ldr_wdata   (ldr_wdata),
    .ldr_gnt     (ldr_gnt),
    .ldr_rvalid  (ldr_rvalid),
    .ldr_rdata   (ldr_rdata),
    .boot_done   (boot_done),
    .halt_req    (halt_req),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .state_o     (state_o),
    .ldr_starved (ldr_starved)
  );

  // RAM macro model: write-through storage, registered read data.
  always @(posedge clkin) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Scoreboard: every loader read return must match the oldest expected value.
  always @(negedge clkin) begin
    if (ldr_rvalid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_rvalid: ldr_rvalid=1 rdata=%h, required no read pending",
                 ldr_rdata);
      end else begin
        sb_exp = sb_q.pop_front();
        if (ldr_rdata !== sb_exp) begin
          failures++;
          $display("FAIL sb_ldr_rdata: got %h, required %h", ldr_rdata, sb_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic drive_idle();
    cpu_en = 1'b0; cpu_rdwr = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
    boot_done = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step();
    step();
    checks++;
    if (state_o !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d, required 0", state_o); end
    checks++;
    if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst: got %b, required 1", cpu_rst); end
    checks++;
    if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b, required 0", ldr_rvalid); end
    checks++;
    if (ldr_starved !== 1'b0) begin failures++; $display("FAIL rst_starved: got %b, required 0", ldr_starved); end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL rst_mem_idle: got en=%b we=%b, required 0 0", mem_en, mem_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_boot_sequence();
    logic [11:0] a [3];
    logic [15:0] d [3];
    a[0] = 12'h000; d[0] = 16'h1234;
    a[1] = 12'h001; d[1] = 16'hABCD;
    a[2] = 12'h002; d[2] = 16'h7000;
    for (int i = 0; i < 3; i++) begin
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = a[i]; ldr_wdata = d[i];
      exp_mem[a[i]] = d[i];
      #1;
      checks++;
      if (ldr_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a[i] ||
          mem_wdata !== d[i]) begin
        failures++;
        $display("FAIL boot_write%0d: got gnt=%b en=%b we=%b addr=%h data=%h, required 1 1 1 %h %h",
                 i, ldr_gnt, mem_en, mem_we, mem_addr, mem_wdata, a[i], d[i]);
      end
      step();
    end
    ldr_req = 1'b0; ldr_we = 1'b0;
    boot_done = 1'b1;
    step();
    boot_done = 1'b0;
    checks++;
    if (state_o !== 2'd1 || cpu_rst !== 1'b1) begin
      failures++; $display("FAIL start_entry: got state=%0d cpu_rst=%b, required 1 1", state_o, cpu_rst);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state_o !== 2'd1 || cpu_rst !== 1'b1) begin
        failures++;
        $display("FAIL start_hold%0d: got state=%0d cpu_rst=%b, required 1 1", i, state_o, cpu_rst);
      end
    end
    step();
    checks++;
    if (state_o !== 2'd2 || cpu_rst !== 1'b0) begin
      failures++; $display("FAIL run_entry: got state=%0d cpu_rst=%b, required 2 0", state_o, cpu_rst);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[a[i]] !== exp_mem[a[i]]) begin
        failures++; $display("FAIL boot_ram%0d: got %h, required %h", i, ram[a[i]], exp_mem[a[i]]);
      end
    end
  endtask

  task automatic test_cpu_priority();
    cpu_en = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 12'h001;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h005; ldr_wdata = 16'h5555;
    #1;
    checks++;
    if (ldr_gnt !== 1'b0 || mem_addr !== 12'h001 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL cpu_wins: got gnt=%b addr=%h en=%b we=%b, required 0 001 1 0",
               ldr_gnt, mem_addr, mem_en, mem_we);
    end
    step();
    cpu_en = 1'b0;
    exp_mem[12'h005] = 16'h5555;
    #1;
    checks++;
    if (cpu_rdata !== exp_mem[12'h001]) begin
      failures++; $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, exp_mem[12'h001]);
    end
    checks++;
    if (ldr_gnt !== 1'b1 || mem_addr !== 12'h005 || mem_we !== 1'b1 || mem_wdata !== 16'h5555) begin
      failures++;
      $display("FAIL ldr_idle_slot: got gnt=%b addr=%h we=%b data=%h, required 1 005 1 5555",
               ldr_gnt, mem_addr, mem_we, mem_wdata);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || ldr_gnt !== 1'b0) begin
      failures++;
      $display("FAIL run_idle: got en=%b we=%b gnt=%b, required 0 0 0", mem_en, mem_we, ldr_gnt);
    end
    checks++;
    if (ram[12'h005] !== exp_mem[12'h005]) begin
      failures++; $display("FAIL ldr_run_write: got %h, required %h", ram[12'h005], exp_mem[12'h005]);
    end
  endtask

  task automatic test_starve();
    cpu_en = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 12'h000;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 12'h002;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (ldr_starved !== (k >= 8)) begin
        failures++;
        $display("FAIL starve_k%0d: got %b, required %b", k, ldr_starved, (k >= 8));
      end
    end
    cpu_en = 1'b0;
    sb_q.push_back(exp_mem[12'h002]);
    #1;
    checks++;
    if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL starve_gnt: got %b, required 1", ldr_gnt); end
    step();
    drive_idle();
    checks++;
    if (ldr_starved !== 1'b0) begin
      failures++; $display("FAIL starve_clear: got %b, required 0", ldr_starved);
    end
    step();
  endtask

  task automatic test_halt();
    cpu_en = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 12'h020; cpu_wdata = 16'hBEEF;
    halt_req = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h020) begin
      failures++;
      $display("FAIL halt_cpu_access: got en=%b we=%b addr=%h, required 1 1 020", mem_en, mem_we, mem_addr);
    end
    step();
    drive_idle();
    exp_mem[12'h020] = 16'hBEEF;
    checks++;
    if (state_o !== 2'd0 || cpu_rst !== 1'b1) begin
      failures++; $display("FAIL halt_state: got state=%0d cpu_rst=%b, required 0 1", state_o, cpu_rst);
    end
    checks++;
    if (ram[12'h020] !== exp_mem[12'h020]) begin
      failures++; $display("FAIL halt_write: got %h, required %h", ram[12'h020], exp_mem[12'h020]);
    end
  endtask

  task automatic test_loader_read();
    // cpu request in BOOT must be ignored
    cpu_en = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 12'h3FF; cpu_wdata = 16'hDEAD;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 12'h001;
    sb_q.push_back(exp_mem[12'h001]);
    #1;
    checks++;
    if (ldr_gnt !== 1'b1 || mem_addr !== 12'h001 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL boot_read_gnt: got gnt=%b addr=%h we=%b, required 1 001 0", ldr_gnt, mem_addr, mem_we);
    end
    step();
    drive_idle();
    checks++;
    if (ldr_rvalid !== 1'b1) begin failures++; $display("FAIL boot_rvalid: got %b, required 1", ldr_rvalid); end
    step();
    checks++;
    if (ldr_rvalid !== 1'b0 || ram[12'h3FF] !== 16'h0000) begin
      failures++;
      $display("FAIL boot_cpu_ignored: got rvalid=%b ram3ff=%h, required 0 0000", ldr_rvalid, ram[12'h3FF]);
    end
  endtask

  task automatic test_rst_in_flight();
    // boot_done concurrent with a loader write: write lands, then START
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h007; ldr_wdata = 16'h0707;
    boot_done = 1'b1;
    exp_mem[12'h007] = 16'h0707;
    #1;
    checks++;
    if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL bootdone_gnt: got %b, required 1", ldr_gnt); end
    step();
    boot_done = 1'b0;
    checks++;
    if (state_o !== 2'd1) begin failures++; $display("FAIL bootdone_state: got %0d, required 1", state_o); end
    // read granted in START while reset hits: data must be dropped
    ldr_we = 1'b0; ldr_addr = 12'h002;
    rst = 1'b1;
    #1;
    checks++;
    if (ldr_gnt !== 1'b1) begin failures++; $display("FAIL start_read_gnt: got %b, required 1", ldr_gnt); end
    step();
    rst = 1'b0;
    drive_idle();
    checks++;
    if (ldr_rvalid !== 1'b0 || state_o !== 2'd0 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL rst_drop: got rvalid=%b state=%0d cpu_rst=%b, required 0 0 1",
               ldr_rvalid, state_o, cpu_rst);
    end
    checks++;
    if (ram[12'h007] !== exp_mem[12'h007]) begin
      failures++; $display("FAIL bootdone_write: got %h, required %h", ram[12'h007], exp_mem[12'h007]);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a [4];
    a[0] = 12'h007; a[1] = 12'h000; a[2] = 12'h001; a[3] = 12'h005;
    for (int i = 0; i < 4; i++) begin
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = a[i];
      sb_q.push_back(exp_mem[a[i]]);
      step();
    end
    drive_idle();
    checks++;
    if (ldr_rvalid !== 1'b1) begin failures++; $display("FAIL b2b_last_rvalid: got %b, required 1", ldr_rvalid); end
    step();
    step();
    checks++;
    if (ldr_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_rvalid_drop: got %b, required 0", ldr_rvalid); end
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d pending reads, required 0", sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'h0000;
      exp_mem[i] = 16'h0000;
    end
    test_reset();
    test_boot_sequence();
    test_cpu_priority();
    test_starve();
    test_halt();
    test_loader_read();
    test_rst_in_flight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
